fifo_lvl: RTL and testbench
===========================

// Module: fifo_lvl
// PURPOSE
//  Synchronous single-clock FIFO with level tracking for core queues (fetch buffer, LSU store queue).
//  Generalises the basic fifo:
//  - full usable depth of 2**DEPTH_BITS entries
//  - occupancy count and programmable almost-full / almost-empty flags
//  - simultaneous push/pop when full
//  - flush, sticky overflow/underflow error flags
// PARAMETERS
//  WIDTH       8                  data word width in bits
//  DEPTH_BITS  2                  log2 of entry count; DEPTH = 2**DEPTH_BITS, all entries usable
//  AFULL_LVL   2**DEPTH_BITS-1    o_almost_full asserted when level >= AFULL_LVL
//  AEMPTY_LVL  1                  o_almost_empty asserted when level <= AEMPTY_LVL
// PORTS
//  i_clk           in   1             clock, rising edge
//  i_reset_n       in   1             reset, asynchronous, active-low
//  i_flush         in   1             synchronous flush: empty the FIFO
//  i_clr_err       in   1             clear sticky error flags
//  i_data          in   WIDTH         write data
//  i_push          in   1             write request
//  o_push_ready    out  1             write would be accepted this cycle
//  i_pop           in   1             read request
//  o_pop_valid     out  1             o_data holds a valid word
//  o_data          out  WIDTH         head-of-queue data
//  o_level         out  DEPTH_BITS+1  stored word count, 0..DEPTH
//  o_empty         out  1             level == 0
//  o_full          out  1             level == DEPTH
//  o_almost_empty  out  1             level <= AEMPTY_LVL
//  o_almost_full   out  1             level >= AFULL_LVL
//  o_overflow      out  1             sticky: a push was dropped
//  o_underflow     out  1             sticky: a pop was issued with no valid data
// BEHAVIOUR
//  - State: head/tail pointers of DEPTH_BITS+1 bits (wrap bit) plus storage array.
//    - Level = head - tail, modulo 2**(DEPTH_BITS+1).
//    - Pointers wrap naturally, DEPTH-1 -> 0 with wrap bit toggled.
//  - Reset (async, i_reset_n=0): pointers, storage and error flags cleared. Resulting outputs:
//    - o_empty=1, o_almost_empty=1, o_push_ready=1
//    - o_level=0, o_data=0, o_pop_valid=0
//    - o_full=0, o_almost_full=0 (for AFULL_LVL>0)
//    - o_overflow=0, o_underflow=0
//  - Status outputs are combinational from registered pointers. A push at edge N is reflected in
//    level/flags/o_data after edge N.
//  - Read is combinational: o_data = storage[tail] when not empty.
//  - push_acc = i_push & (!full | pop_acc); pop_acc = i_pop & !empty.
//    - Full with push+pop in the same cycle: both accepted, level unchanged.
//    - Empty with push+pop in the same cycle: push only (pop rejected), unless FIFO_BYPASS_EN.
//  - o_push_ready = !full | i_pop.
//  - Dropped push (i_push & !push_acc): word discarded, pointers unchanged, o_overflow set next cycle.
//  - Rejected pop (i_pop & !pop_acc & no bypass): no state change, o_underflow set next cycle.
//  - i_clr_err clears both sticky flags. A new error in the same cycle wins: the flag stays 1.
//  - i_flush has priority over push/pop:
//    - head<=0, tail<=0; push and pop in that cycle ignored and raise no error flags.
//    - Storage contents are not cleared; o_data reads 0-slot but o_pop_valid=0.
//  - Reset asserted mid-operation: immediate async clear, all in-flight data lost.
// CONFIGURATION
//  FIFO_BYPASS_EN defined:
//    - When empty, o_data = i_data and o_pop_valid = i_push.
//    - Push+pop while empty passes the word through: not stored, level stays 0, no underflow.
//    - Flush cycle suppresses bypass: o_pop_valid=0.
//  FIFO_BYPASS_EN undefined:
//    - o_pop_valid = !o_empty.
//    - Pop while empty is always rejected and sets o_underflow, even with a simultaneous push.
// TESTING (WIDTH=8, DEPTH_BITS=2, defaults)
//  1. Reset, then push 0x11,0x22,0x33,0x44 -> level 1..4; o_full=1 after 4th; o_almost_full=1 from
//     level 3; pop x4 returns 0x11..0x44 in order; o_empty=1.
//  2. Full, push 0x55 without pop -> word dropped, level stays 4, o_overflow=1. i_clr_err -> 0.
//     i_clr_err with a same-cycle drop -> stays 1.
//  3. Full, push 0x66 + pop same cycle -> pops 0x11, level 4, next pops 0x22,0x33,0x44,0x66.
//  4. 10 interleaved push/pop cycles at level 2 -> pointers wrap twice, data order preserved,
//     no flags set.
//  5. Level 3, i_flush with push 0x77 -> level 0, o_empty=1, 0x77 not stored, no error flags.
//     Assert i_reset_n=0 mid-stream between edges -> outputs reset immediately.
//  6. Empty, push 0x88 + pop same cycle:
//     - FIFO_BYPASS_EN: o_data=0x88, o_pop_valid=1, level 0.
//     - else: level 1, o_underflow=1.

Source files
------------

// File: rtl/fifo_lvl.sv
// fifo_lvl: single-clock FIFO with occupancy level, almost-full/almost-empty flags and sticky errors.
// Optional feature macro FIFO_BYPASS_EN: an empty FIFO hands a same-cycle push straight to a pop.
module fifo_lvl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 2,
  parameter int unsigned AFULL_LVL  = (2**DEPTH_BITS) - 1,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_push,
  output logic                  o_push_ready,
  input  logic                  i_pop,
  output logic                  o_pop_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic [DEPTH_BITS:0]   o_level,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_empty,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned         DEPTH    = 2**DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_L  = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AFULL_L  = (DEPTH_BITS+1)'(AFULL_LVL);
  localparam logic [DEPTH_BITS:0] AEMPTY_L = (DEPTH_BITS+1)'(AEMPTY_LVL);
  localparam logic [DEPTH_BITS:0] ZERO_L   = {(DEPTH_BITS+1){1'b0}};

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [DEPTH_BITS:0] head_r, tail_r, level_s;
  logic                empty_s, full_s, pop_acc_s, push_acc_s, bypass_s;
  logic                wr_en_s, ovf_evt_s, unf_evt_s;
  logic                ovf_r, unf_r;

  function automatic logic [DEPTH_BITS:0] ptr_inc(input logic [DEPTH_BITS:0] ptr);
    return ptr + {{DEPTH_BITS{1'b0}}, 1'b1};
  endfunction

  // Accept/reject decisions and error events for the current cycle
  always_comb begin
    level_s    = head_r - tail_r;
    empty_s    = (level_s == ZERO_L);
    full_s     = (level_s == DEPTH_L);
    pop_acc_s  = i_pop & ~empty_s;
    push_acc_s = i_push & (~full_s | pop_acc_s);
`ifdef FIFO_BYPASS_EN
    bypass_s   = empty_s & i_push & i_pop & ~i_flush;
`else
    bypass_s   = 1'b0;
`endif
    // flush swallows both requests without flagging them as errors
    wr_en_s    = push_acc_s & ~bypass_s & ~i_flush;
    ovf_evt_s  = i_push & ~push_acc_s & ~i_flush;
    unf_evt_s  = i_pop & ~pop_acc_s & ~bypass_s & ~i_flush;
  end

  // Head/tail pointer update, flush returns both to slot 0
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_r <= ZERO_L;
      tail_r <= ZERO_L;
    end else if (i_flush) begin
      head_r <= ZERO_L;
      tail_r <= ZERO_L;
    end else begin
      if (wr_en_s) begin
        head_r <= ptr_inc(head_r);
      end
      if (pop_acc_s) begin
        tail_r <= ptr_inc(tail_r);
      end
    end
  end

  // Storage array write port
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[head_r[DEPTH_BITS-1:0]] <= i_data;
    end
  end

  // Sticky error flags, a new error outranks a same-cycle clear
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end else if (i_clr_err) begin
        ovf_r <= 1'b0;
      end
      if (unf_evt_s) begin
        unf_r <= 1'b1;
      end else if (i_clr_err) begin
        unf_r <= 1'b0;
      end
    end
  end

  assign o_level        = level_s;
  assign o_empty        = empty_s;
  assign o_full         = full_s;
  assign o_almost_empty = (level_s <= AEMPTY_L);
  assign o_almost_full  = (level_s >= AFULL_L);
  assign o_push_ready   = ~full_s | i_pop;
  assign o_overflow     = ovf_r;
  assign o_underflow    = unf_r;

`ifdef FIFO_BYPASS_EN
  assign o_data      = empty_s ? i_data : mem_r[tail_r[DEPTH_BITS-1:0]];
  assign o_pop_valid = ~empty_s | (i_push & ~i_flush);
`else
  assign o_data      = mem_r[tail_r[DEPTH_BITS-1:0]];
  assign o_pop_valid = ~empty_s;
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: randomized + directed bench for fifo_lvl with a queue-based reference model
// and a scoreboard monitor that checks every popped word.
module tb_fifo_lvl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, clr_err, push, pop;
  logic [7:0] din;
  logic       push_ready, pop_valid;
  logic [7:0] dout;
  logic [2:0] level;
  logic       empty, full, aempty, afull, ovf, unf;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];     // reference FIFO contents
  logic [7:0] exp_q[$];  // scoreboard: words expected at the output
  bit         m_ovf, m_unf;

  fifo_lvl #(.WIDTH(8), .DEPTH_BITS(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
    .i_data(din), .i_push(push), .o_push_ready(push_ready), .i_pop(pop),
    .o_pop_valid(pop_valid), .o_data(dout), .o_level(level), .o_empty(empty),
    .o_full(full), .o_almost_empty(aempty), .o_almost_full(afull),
    .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = mq.size();
    chk("level", 32'(level), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_empty", 32'(aempty), 32'(n <= 1));
    chk("almost_full", 32'(afull), 32'(n >= DEPTH - 1));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(unf), 32'(m_unf));
  endtask

  // one clock of stimulus; reference model advanced by the FIFO rules
  task automatic step(input bit p_push, input bit p_pop, input bit p_flush, input bit p_clr,
                      input logic [7:0] d);
    int n;
    bit pop_ok, push_ok, byp, ovf_ev, unf_ev;
    @(negedge clk);
    check_status();
    push = p_push; pop = p_pop; flush = p_flush; clr_err = p_clr; din = d;
    #2;
    n = mq.size();
    byp = 1'b0;
`ifdef FIFO_BYPASS_EN
    byp = (n == 0) && p_push && p_pop && !p_flush;
    chk("pop_valid", 32'(pop_valid), 32'((n > 0) || (p_push && !p_flush)));
`else
    chk("pop_valid", 32'(pop_valid), 32'(n > 0));
`endif
    chk("push_ready", 32'(push_ready), 32'((n < DEPTH) || p_pop));
    ovf_ev = 1'b0; unf_ev = 1'b0;
    if (p_flush) begin
      mq.delete();
    end else if (byp) begin
      exp_q.push_back(d);
    end else begin
      pop_ok  = p_pop && (n > 0);
      push_ok = p_push && ((n < DEPTH) || pop_ok);
      if (pop_ok) exp_q.push_back(mq.pop_front());
      if (push_ok) mq.push_back(d);
      ovf_ev = p_push && !push_ok;
      unf_ev = p_pop && !pop_ok;
    end
    m_ovf = ovf_ev ? 1'b1 : (p_clr ? 1'b0 : m_ovf);
    m_unf = unf_ev ? 1'b1 : (p_clr ? 1'b0 : m_unf);
  endtask

  // scoreboard monitor: compare every handshaked output word
  always @(negedge clk) begin
    #3;
    if (rst_n && pop && pop_valid && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        chk("pop_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_aempty"}, 32'(aempty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(afull), 32'd0);
    chk({tag, "_push_ready"}, 32'(push_ready), 32'd1);
    chk({tag, "_pop_valid"}, 32'(pop_valid), 32'd0);
    chk({tag, "_data"}, 32'(dout), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_unf"}, 32'(unf), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
    m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // fill, overflow, clear, clear-vs-drop race
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, pat[i]);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    // full with push+pop, then drain
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h66);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // interleaved traffic at level 2 wraps the pointers
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
    // flush at level 3 with a same-cycle push
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // push+pop while empty
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h88);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hC1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hC2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);

    // asynchronous reset between edges
    @(posedge clk);
    #2;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
           $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
